// File: rtl/seg_addr_gen.sv
// Physical address generator: segment select (with one-shot data override) and (seg<<4)+offset,
// presented through a single registered valid/ready stage. Optional SEG_ADDR_WRAP_FLAG_EN adds pa_wrap.
module seg_addr_gen #(
  parameter int SEG_W = 8,
  parameter int OFF_W = 8,
  parameter int PA_W  = SEG_W + 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEG_W-1:0] CS,
  input  logic [SEG_W-1:0] DS,
  input  logic [SEG_W-1:0] SS,
  input  logic [SEG_W-1:0] ES,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [OFF_W-1:0] req_offset,
  input  logic             ovr_valid,
  input  logic [1:0]       ovr_seg,
  output logic             pa_valid,
  input  logic             pa_ready,
  output logic [PA_W-1:0]  pa,
`ifdef SEG_ADDR_WRAP_FLAG_EN
  output logic             pa_wrap,
`endif
  output logic [1:0]       pa_seg
);

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } ovr_state_t;

  localparam logic [1:0] KIND_DATA = 2'b01;

  ovr_state_t r_state, w_state_nxt;
  logic [1:0]       r_ovr_seg, w_ovr_seg_nxt;
  logic             r_pa_valid;
  logic [PA_W-1:0]  r_pa;
  logic [1:0]       r_pa_seg;

  logic             w_accept;
  logic             w_data_accept;
  logic [1:0]       w_sel;
  logic [SEG_W-1:0] w_seg_val;
  logic [PA_W:0]    w_sum;

  assign req_ready     = !r_pa_valid || pa_ready;
  assign w_accept      = req_valid && req_ready;
  assign w_data_accept = w_accept && (req_kind == KIND_DATA);

  // A same-cycle override pulse beats any latched segment; overrides only touch data accesses.
  always_comb begin
    w_sel = req_kind;
    if (req_kind == KIND_DATA) begin
      if (ovr_valid)
        w_sel = ovr_seg;
      else if (r_state == S_ARMED)
        w_sel = r_ovr_seg;
    end
  end

  always_comb begin
    w_seg_val = CS;
    case (w_sel)
      2'b00:   w_seg_val = CS;
      2'b01:   w_seg_val = DS;
      2'b10:   w_seg_val = SS;
      default: w_seg_val = ES;
    endcase
  end

  assign w_sum = (PA_W+1)'({w_seg_val, 4'b0000}) + (PA_W+1)'(req_offset);

  always_comb begin
    w_state_nxt   = r_state;
    w_ovr_seg_nxt = r_ovr_seg;
    if (w_data_accept) begin
      w_state_nxt = S_IDLE;
    end else if (ovr_valid) begin
      w_state_nxt   = S_ARMED;
      w_ovr_seg_nxt = ovr_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ovr_seg <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ovr_seg <= w_ovr_seg_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pa_valid <= 1'b0;
      r_pa       <= '0;
      r_pa_seg   <= '0;
    end else if (w_accept) begin
      r_pa_valid <= 1'b1;
      r_pa       <= w_sum[PA_W-1:0];
      r_pa_seg   <= w_sel;
    end else if (pa_ready) begin
      r_pa_valid <= 1'b0;
    end
  end

`ifdef SEG_ADDR_WRAP_FLAG_EN
  logic r_pa_wrap;
  always_ff @(posedge clk) begin
    if (rst)
      r_pa_wrap <= 1'b0;
    else if (w_accept)
      r_pa_wrap <= w_sum[PA_W];
  end
  assign pa_wrap = r_pa_wrap;
`endif

  assign pa_valid = r_pa_valid;
  assign pa       = r_pa;
  assign pa_seg   = r_pa_seg;

endmodule

// File: tb/tb_seg_addr_gen.sv
// Directed self-checking bench for seg_addr_gen with hand-computed addresses.
module tb_seg_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  CS, DS, SS, ES;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_kind;
  logic [7:0]  req_offset;
  logic        ovr_valid;
  logic [1:0]  ovr_seg;
  logic        pa_valid;
  logic        pa_ready;
  logic [11:0] pa;
  logic [1:0]  pa_seg;
`ifdef SEG_ADDR_WRAP_FLAG_EN
  logic        pa_wrap;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_addr_gen #(.SEG_W(8), .OFF_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .CS         (CS),
    .DS         (DS),
    .SS         (SS),
    .ES         (ES),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_kind   (req_kind),
    .req_offset (req_offset),
    .ovr_valid  (ovr_valid),
    .ovr_seg    (ovr_seg),
    .pa_valid   (pa_valid),
    .pa_ready   (pa_ready),
    .pa         (pa),
`ifdef SEG_ADDR_WRAP_FLAG_EN
    .pa_wrap    (pa_wrap),
`endif
    .pa_seg     (pa_seg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] kind, input logic [7:0] off);
    req_valid  = 1'b1;
    req_kind   = kind;
    req_offset = off;
  endtask

  task automatic expect_pa(input string tag, input logic [11:0] a, input logic [1:0] s);
    check({tag, "_valid"}, {31'd0, pa_valid}, 32'd1);
    check({tag, "_pa"},    {20'd0, pa},       {20'd0, a});
    check({tag, "_seg"},   {30'd0, pa_seg},   {30'd0, s});
  endtask

  initial begin
    rst = 1'b1; CS = 8'h12; DS = 8'hFF; SS = 8'h20; ES = 8'h40;
    req_valid = 1'b0; req_kind = 2'b00; req_offset = 8'h00;
    ovr_valid = 1'b0; ovr_seg = 2'b00; pa_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_valid", {31'd0, pa_valid}, 32'd0);
    check("rst_pa",    {20'd0, pa},       32'd0);
    check("rst_seg",   {30'd0, pa_seg},   32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    // Fetch from CS
    req(2'b00, 8'h34); step();
    expect_pa("fetch", 12'h154, 2'b00);

    // Data from DS with wrap, issued back-to-back
    req(2'b01, 8'hF0); step();
    expect_pa("wrap", 12'h0E0, 2'b01);
`ifdef SEG_ADDR_WRAP_FLAG_EN
    check("wrap_flag", {31'd0, pa_wrap}, 32'd1);
`endif
    req_valid = 1'b0; step();
    check("drain_valid", {31'd0, pa_valid}, 32'd0);

    // Override to ES, then data uses ES once, then DS again
    ovr_valid = 1'b1; ovr_seg = 2'b11; step();
    ovr_valid = 1'b0;
    check("armed_idle_valid", {31'd0, pa_valid}, 32'd0);
    req(2'b01, 8'h05); step();
    expect_pa("ovr_es", 12'h405, 2'b11);
`ifdef SEG_ADDR_WRAP_FLAG_EN
    check("nowrap_flag", {31'd0, pa_wrap}, 32'd0);
`endif
    req(2'b01, 8'h05); step();
    expect_pa("after_ovr", 12'hFF5, 2'b01);

    // Armed override survives a stack access
    req_valid = 1'b0; ovr_valid = 1'b1; ovr_seg = 2'b11; step();
    ovr_valid = 1'b0;
    req(2'b10, 8'h02); step();
    expect_pa("stack_armed", 12'h202, 2'b10);
    req(2'b01, 8'h05); step();
    expect_pa("armed_data", 12'h405, 2'b11);
    req(2'b01, 8'h05); step();
    expect_pa("disarmed", 12'hFF5, 2'b01);

    // Same-cycle pulse beats the latched segment
    req_valid = 1'b0; ovr_valid = 1'b1; ovr_seg = 2'b10; step();
    ovr_seg = 2'b00; req(2'b01, 8'h05); step();
    ovr_valid = 1'b0;
    expect_pa("pulse_wins", 12'h125, 2'b00);
    req(2'b01, 8'h05); step();
    expect_pa("pulse_clears", 12'hFF5, 2'b01);

    // Backpressure: output held, request stalled, segment changes ignored
    req(2'b00, 8'h34); step();
    expect_pa("bp_load", 12'h154, 2'b00);
    pa_ready = 1'b0; req(2'b10, 8'h02); CS = 8'h55;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_pa("bp_hold", 12'h154, 2'b00);
      check("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    pa_ready = 1'b1; #1;
    check("bp_release_ready", {31'd0, req_ready}, 32'd1);
    step();
    expect_pa("bp_queued", 12'h202, 2'b10);
    req_valid = 1'b0; step();
    check("bp_drain", {31'd0, pa_valid}, 32'd0);
    CS = 8'h12;

    // Reset while valid and armed, with a transfer also pending
    ovr_valid = 1'b1; ovr_seg = 2'b11; step();
    ovr_valid = 1'b0;
    req(2'b00, 8'h34); step();
    expect_pa("pre_rst", 12'h154, 2'b00);
    rst = 1'b1; req(2'b01, 8'h07); step();
    rst = 1'b0; req_valid = 1'b0;
    check("rst2_valid", {31'd0, pa_valid}, 32'd0);
    check("rst2_pa",    {20'd0, pa},       32'd0);
    check("rst2_seg",   {30'd0, pa_seg},   32'd0);
    req(2'b01, 8'h05); step();
    expect_pa("post_rst", 12'hFF5, 2'b01);
    req_valid = 1'b0; step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
